dc_sweep_sequencer: RTL and testbench

//  Sequences a DC operating-point sweep of a netlisted subcircuit (e.g. source V1 driving a nested
//  RC subcircuit into a load resistor). It steps the source setpoint from start to stop, handshakes

---
 rtl/dc_sweep_sequencer.sv | 145 ++++++++++++++
 tb/tb_dc_sweep_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dc_sweep_sequencer.sv
// DC sweep sequencer: steps a source setpoint from v_start to v_stop, handshakes each
// point with the solver core and streams per-point results out over valid/ready.
module dc_sweep_sequencer #(
    parameter int VW     = 16,
    parameter int TOW    = 12,
    parameter int SETTLE = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [VW-1:0] v_start,
    input  logic [VW-1:0] v_stop,
    input  logic [VW-1:0] v_step,
    input  logic [TOW-1:0] to_lim,
    output logic          busy,
    output logic          done,
    output logic [1:0]    status,
    output logic [VW-1:0] sol_vset,
    output logic          sol_req,
    input  logic          sol_ack,
    input  logic          sol_conv,
    input  logic [VW-1:0] sol_vout,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [VW-1:0] res_vset,
    output logic [VW-1:0] res_vout,
    output logic          res_conv
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_SOLVE,
        S_EMIT,
        S_FIN
    } state_t;

    state_t         state, state_nx;
    logic [VW-1:0]  stop_q, step_q;
    logic [TOW-1:0] tolim_q, cnt;
    logic [1:0]     status_nx;
    logic [VW:0]    next_v;
    logic [TOW:0]   cnt_inc;
    logic           cfg_bad, do_load, do_capture, do_advance;

    always_comb begin
        state_nx   = state;
        status_nx  = status;
        do_load    = 1'b0;
        do_capture = 1'b0;
        do_advance = 1'b0;
        next_v     = {1'b0, sol_vset} + {1'b0, step_q};
        cnt_inc    = {1'b0, cnt} + (TOW+1)'(1);
        cfg_bad    = (v_step == '0) || (v_start > v_stop);
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (cfg_bad) begin
                        status_nx = 2'b01;
                        state_nx  = S_FIN;
                    end else begin
                        status_nx = 2'b00;
                        do_load   = 1'b1;
                        state_nx  = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    status_nx = 2'b11;
                    state_nx  = S_FIN;
                end else if (cnt == TOW'(SETTLE - 1)) begin
                    state_nx = S_SOLVE;
                end
            end
            S_SOLVE: begin
                // ack takes priority over a timeout landing in the same cycle
                if (abort) begin
                    status_nx = 2'b11;
                    state_nx  = S_FIN;
                end else if (sol_ack) begin
                    do_capture = 1'b1;
                    state_nx   = S_EMIT;
                end else if (cnt_inc >= {1'b0, tolim_q}) begin
                    status_nx = 2'b10;
                    state_nx  = S_FIN;
                end
            end
            S_EMIT: begin
                if (abort) begin
                    status_nx = 2'b11;
                    state_nx  = S_FIN;
                end else if (res_ready) begin
                    if (next_v[VW] || (next_v[VW-1:0] > stop_q)) begin
                        state_nx = S_FIN;
                    end else begin
                        do_advance = 1'b1;
                        state_nx   = S_SETTLE;
                    end
                end
            end
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            status   <= '0;
            stop_q   <= '0;
            step_q   <= '0;
            tolim_q  <= '0;
            sol_vset <= '0;
            res_vset <= '0;
            res_vout <= '0;
            res_conv <= 1'b0;
        end else begin
            state  <= state_nx;
            status <= status_nx;
            // one counter serves both the settle window and the ack timeout
            cnt    <= (state_nx != state) ? '0 : cnt + TOW'(1);
            if (do_load) begin
                stop_q   <= v_stop;
                step_q   <= v_step;
                tolim_q  <= to_lim;
                sol_vset <= v_start;
            end
            if (do_advance) sol_vset <= next_v[VW-1:0];
            if (do_capture) begin
                res_vset <= sol_vset;
                res_vout <= sol_vout;
                res_conv <= sol_conv;
            end
        end
    end

    assign busy      = (state == S_SETTLE) || (state == S_SOLVE) || (state == S_EMIT);
    assign done      = (state == S_FIN);
    assign sol_req   = (state == S_SOLVE);
    assign res_valid = (state == S_EMIT);

endmodule

// File: tb/tb_dc_sweep_sequencer.sv
// Directed bench for dc_sweep_sequencer: sweeps, bad configs, timeouts, backpressure,
// carry termination, abort and mid-sweep reset, checked with immediate assertions.
module tb_dc_sweep_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [15:0] v_start, v_stop, v_step;
    logic [11:0] to_lim;
    logic        busy, done;
    logic [1:0]  status;
    logic [15:0] sol_vset;
    logic        sol_req, sol_ack, sol_conv;
    logic [15:0] sol_vout;
    logic        res_valid, res_ready;
    logic [15:0] res_vset, res_vout;
    logic        res_conv;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    dc_sweep_sequencer #(.VW(16), .TOW(12), .SETTLE(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .v_start(v_start), .v_stop(v_stop), .v_step(v_step), .to_lim(to_lim),
        .busy(busy), .done(done), .status(status),
        .sol_vset(sol_vset), .sol_req(sol_req), .sol_ack(sol_ack),
        .sol_conv(sol_conv), .sol_vout(sol_vout),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_vset(res_vset), .res_vout(res_vout), .res_conv(res_conv)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_start(input logic [15:0] vs, input logic [15:0] ve,
                            input logic [15:0] vst, input logic [11:0] tl);
        v_start = vs; v_stop = ve; v_step = vst; to_lim = tl;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Waits out the settle window; expects exactly 4 cycles before sol_req rises.
    task automatic wait_req(input string tag, input logic [15:0] exp_vset);
        int n = 0;
        while (!sol_req && n < 50) begin
            n++;
            tick();
        end
        chk({tag, " settle"}, n, 4);
        chk({tag, " vset"}, {16'h0, sol_vset}, {16'h0, exp_vset});
    endtask

    task automatic solve_point(input string tag, input logic [15:0] exp_vset, input int lat,
                               input logic conv, input logic [15:0] vout);
        wait_req(tag, exp_vset);
        repeat (lat - 1) tick();
        sol_ack = 1'b1; sol_conv = conv; sol_vout = vout;
        tick();
        sol_ack = 1'b0; sol_conv = 1'b0; sol_vout = '0;
        chk({tag, " valid"}, {31'h0, res_valid}, 1);
        chk({tag, " rvset"}, {16'h0, res_vset}, {16'h0, exp_vset});
        chk({tag, " rvout"}, {16'h0, res_vout}, {16'h0, vout});
        chk({tag, " rconv"}, {31'h0, res_conv}, {31'h0, conv});
        chk({tag, " reqlow"}, {31'h0, sol_req}, 0);
    endtask

    task automatic chk_done(input string tag, input logic [1:0] exp_status);
        chk({tag, " done"}, {31'h0, done}, 1);
        chk({tag, " busy"}, {31'h0, busy}, 0);
        chk({tag, " status"}, {30'h0, status}, {30'h0, exp_status});
        chk({tag, " novalid"}, {31'h0, res_valid}, 0);
        tick();
        chk({tag, " donepulse"}, {31'h0, done}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int  n;
        logic flag;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        v_start = '0; v_stop = '0; v_step = '0; to_lim = '0;
        sol_ack = 1'b0; sol_conv = 1'b0; sol_vout = '0; res_ready = 1'b1;
        repeat (2) tick();
        chk("rst busy", {31'h0, busy}, 0);
        chk("rst done", {31'h0, done}, 0);
        chk("rst status", {30'h0, status}, 0);
        chk("rst req", {31'h0, sol_req}, 0);
        chk("rst valid", {31'h0, res_valid}, 0);
        chk("rst vset", {16'h0, sol_vset}, 0);
        rst = 1'b0;
        tick();

        // abort while idle does nothing
        abort = 1'b1; tick(); abort = 1'b0;
        chk("idle abort busy", {31'h0, busy}, 0);
        chk("idle abort done", {31'h0, done}, 0);

        // T1: 0..10 step 5, three beats, middle one non-converged
        do_start(16'd0, 16'd10, 16'd5, 12'd100);
        chk("T1 busy", {31'h0, busy}, 1);
        solve_point("T1p1", 16'd0, 3, 1'b1, 16'h1234);
        tick();
        solve_point("T1p2", 16'd5, 3, 1'b0, 16'h2345);
        tick();
        solve_point("T1p3", 16'd10, 3, 1'b1, 16'h3456);
        tick();
        chk_done("T1", 2'b00);

        // T2: bad configs finish one cycle after start with no beats
        do_start(16'd0, 16'd10, 16'd0, 12'd100);
        chk_done("T2a", 2'b01);
        do_start(16'd20, 16'd10, 16'd1, 12'd100);
        chk_done("T2b", 2'b01);

        // T3: no ack, to_lim=8 -> request held exactly 8 cycles
        do_start(16'd0, 16'd10, 16'd5, 12'd8);
        wait_req("T3", 16'd0);
        n = 0; flag = 1'b0;
        while (sol_req && n < 100) begin
            n++;
            if (res_valid) flag = 1'b1;
            tick();
        end
        chk("T3 reqcycles", n, 8);
        chk("T3 nobeat", {31'h0, flag}, 0);
        chk_done("T3", 2'b10);
        sol_ack = 1'b1; sol_vout = 16'hDEAD; tick(); sol_ack = 1'b0;
        tick();
        chk("T3 lateack valid", {31'h0, res_valid}, 0);
        chk("T3 lateack status", {30'h0, status}, 2'b10);

        // to_lim=0 times out after a single request cycle
        do_start(16'd0, 16'd10, 16'd5, 12'd0);
        wait_req("T3z", 16'd0);
        n = 0;
        while (sol_req && n < 100) begin
            n++;
            tick();
        end
        chk("T3z reqcycles", n, 1);
        chk_done("T3z", 2'b10);

        // T4: backpressure on beat 2 holds everything stable
        do_start(16'd0, 16'd10, 16'd5, 12'd100);
        solve_point("T4p1", 16'd0, 3, 1'b1, 16'h0111);
        tick();
        res_ready = 1'b0;
        solve_point("T4p2", 16'd5, 3, 1'b1, 16'h0222);
        flag = 1'b1;
        repeat (5) begin
            if (!(res_valid && res_vset == 16'd5 && res_vout == 16'h0222 && res_conv &&
                  !sol_req && sol_vset == 16'd5)) flag = 1'b0;
            tick();
        end
        chk("T4 hold", {31'h0, flag}, 1);
        chk("T4 stillvalid", {31'h0, res_valid}, 1);
        res_ready = 1'b1;
        tick();
        solve_point("T4p3", 16'd10, 3, 1'b0, 16'h0333);
        tick();
        chk_done("T4", 2'b00);

        // T5: carry ends the sweep; to_lim=3 with ack on the 3rd cycle -> ack wins
        do_start(16'hFFF0, 16'hFFFF, 16'h0008, 12'd3);
        solve_point("T5p1", 16'hFFF0, 3, 1'b1, 16'h00AA);
        tick();
        solve_point("T5p2", 16'hFFF8, 3, 1'b1, 16'h00BB);
        tick();
        chk_done("T5", 2'b00);

        // T6: abort during SOLVE of point 2
        do_start(16'd0, 16'd10, 16'd5, 12'd100);
        solve_point("T6p1", 16'd0, 3, 1'b1, 16'h0C01);
        tick();
        wait_req("T6p2", 16'd5);
        tick();
        abort = 1'b1; tick(); abort = 1'b0;
        chk("T6 reqlow", {31'h0, sol_req}, 0);
        chk_done("T6", 2'b11);
        sol_ack = 1'b1; tick(); sol_ack = 1'b0;
        tick();
        chk("T6 lateack valid", {31'h0, res_valid}, 0);
        chk("T6 lateack status", {30'h0, status}, 2'b11);

        // start with abort in IDLE is taken; then reset mid-sweep with a beat pending
        abort = 1'b1;
        do_start(16'd3, 16'd10, 16'd5, 12'd100);
        abort = 1'b0;
        chk("T6r busy", {31'h0, busy}, 1);
        chk("T6r status", {30'h0, status}, 2'b00);
        res_ready = 1'b0;
        solve_point("T6r", 16'd3, 2, 1'b1, 16'h0BEE);
        rst = 1'b1; tick();
        chk("T6r rst busy", {31'h0, busy}, 0);
        chk("T6r rst done", {31'h0, done}, 0);
        chk("T6r rst status", {30'h0, status}, 0);
        chk("T6r rst req", {31'h0, sol_req}, 0);
        chk("T6r rst valid", {31'h0, res_valid}, 0);
        chk("T6r rst vset", {16'h0, sol_vset}, 0);
        chk("T6r rst rvset", {16'h0, res_vset}, 0);
        chk("T6r rst rvout", {16'h0, res_vout}, 0);
        chk("T6r rst rconv", {31'h0, res_conv}, 0);
        rst = 1'b0; res_ready = 1'b1;
        flag = 1'b0;
        repeat (4) begin
            tick();
            if (done || busy) flag = 1'b1;
        end
        chk("T6r nodone", {31'h0, flag}, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
